// File: rtl/burst_compare_engine_if.sv
// Packet, read-return and result signals of the burst compare engine.
interface burst_compare_engine_if #(
    parameter int unsigned AMM_DATA_W  = 128,
    parameter int unsigned AMM_ADDR_W  = 12,
    parameter int unsigned AMM_BURST_W = 11,
    parameter int unsigned ERR_CNT_W   = 16
);
    localparam int unsigned BYTE_PER_WORD = AMM_DATA_W / 8;
    localparam int unsigned BYTE_ADDR_W   = $clog2(BYTE_PER_WORD);
    localparam int unsigned ADDR_W        = AMM_ADDR_W - BYTE_ADDR_W;

    logic                   start_test_i;
    logic                   cont_on_err_i;
    logic                   readdatavalid_i;
    logic [AMM_DATA_W-1:0]  readdata_i;
    logic                   cmp_pkt_en_i;
    logic [ADDR_W-1:0]      cmp_word_addr_i;
    logic [AMM_BURST_W-1:0] cmp_burstcount_i;
    logic [BYTE_ADDR_W-1:0] cmp_start_off_i;
    logic [BYTE_ADDR_W-1:0] cmp_end_off_i;
    logic [7:0]             cmp_data_ptrn_i;
    logic                   cmp_data_rnd_i;
    logic                   cmp_pkt_ready_o;
    logic                   check_result_valid_o;
    logic                   check_result_o;
    logic [AMM_ADDR_W-1:0]  check_error_address_o;
    logic [ERR_CNT_W-1:0]   error_cnt_o;
    logic                   unexp_data_o;
    logic                   busy_o;

    modport master (
        output start_test_i, cont_on_err_i, readdatavalid_i, readdata_i,
               cmp_pkt_en_i, cmp_word_addr_i, cmp_burstcount_i, cmp_start_off_i,
               cmp_end_off_i, cmp_data_ptrn_i, cmp_data_rnd_i,
        input  cmp_pkt_ready_o, check_result_valid_o, check_result_o,
               check_error_address_o, error_cnt_o, unexp_data_o, busy_o
    );

    modport slave (
        input  start_test_i, cont_on_err_i, readdatavalid_i, readdata_i,
               cmp_pkt_en_i, cmp_word_addr_i, cmp_burstcount_i, cmp_start_off_i,
               cmp_end_off_i, cmp_data_ptrn_i, cmp_data_rnd_i,
        output cmp_pkt_ready_o, check_result_valid_o, check_result_o,
               check_error_address_o, error_cnt_o, unexp_data_o, busy_o
    );
endinterface

// File: rtl/burst_compare_engine.sv
// Compares Avalon-MM read bursts against queued fixed/LFSR byte patterns.
module burst_compare_engine #(
    parameter int unsigned AMM_DATA_W     = 128,
    parameter int unsigned AMM_ADDR_W     = 12,
    parameter int unsigned AMM_BURST_W    = 11,
    parameter int unsigned PKT_FIFO_DEPTH = 4,
    parameter int unsigned ERR_CNT_W      = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    burst_compare_engine_if.slave  bus
);
    localparam int unsigned BYTE_PER_WORD = AMM_DATA_W / 8;
    localparam int unsigned BYTE_ADDR_W   = $clog2(BYTE_PER_WORD);
    localparam int unsigned ADDR_W        = AMM_ADDR_W - BYTE_ADDR_W;
    localparam int unsigned PTR_W         = $clog2(PKT_FIFO_DEPTH);
    localparam int unsigned PCNT_W        = PTR_W + 1;
    localparam int unsigned CNT_W         = AMM_BURST_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0]      word_addr;
        logic [AMM_BURST_W-1:0] burstcount;
        logic [BYTE_ADDR_W-1:0] start_off;
        logic [BYTE_ADDR_W-1:0] end_off;
        logic [7:0]             ptrn;
        logic                   rnd;
    } pkt_t;

    typedef enum logic [1:0] {IDLE, LOAD, CHECK, HALT} state_t;

    state_t                   state_q;
    pkt_t                     fifo_q [PKT_FIFO_DEPTH];
    logic [PCNT_W-1:0]        wr_ptr_q, rd_ptr_q, fifo_cnt_c;
    logic                     full_c, empty_c, ready_c, push_c;
    pkt_t                     pkt_in_c, head_c;

    logic [ADDR_W-1:0]        addr_q, cur_addr;
    logic [BYTE_ADDR_W-1:0]   start_q, end_q, cur_start, cur_end;
    logic [7:0]               ptrn_q, lfsr_q, cur_ptrn, cur_lfsr, lfsr_nxt_c, exp_c;
    logic                     rnd_q, cur_rnd;
    logic [CNT_W-1:0]         idx_q, left_q, cur_idx, cur_left, total_c;
    logic                     first_c, last_c, word_acc_c, halt_c;
    logic [BYTE_PER_WORD-1:0] fail_c;

    logic                     s1_vld_q, s1_last_q, s1_err_c;
    logic [BYTE_PER_WORD-1:0] s1_fail_q;
    logic [ADDR_W-1:0]        s1_addr_q;
    logic [BYTE_ADDR_W-1:0]   low_idx_c;

    logic                     valid_q, result_q, unexp_q, pkt_err_q;
    logic [AMM_ADDR_W-1:0]    err_addr_q;
    logic [ERR_CNT_W-1:0]     err_cnt_q;

    assign pkt_in_c.word_addr  = bus.cmp_word_addr_i;
    assign pkt_in_c.burstcount = bus.cmp_burstcount_i;
    assign pkt_in_c.start_off  = bus.cmp_start_off_i;
    assign pkt_in_c.end_off    = bus.cmp_end_off_i;
    assign pkt_in_c.ptrn       = bus.cmp_data_ptrn_i;
    assign pkt_in_c.rnd        = bus.cmp_data_rnd_i;

    assign head_c     = fifo_q[rd_ptr_q[PTR_W-1:0]];
    assign fifo_cnt_c = wr_ptr_q - rd_ptr_q;
    assign full_c     = (fifo_cnt_c == PCNT_W'(PKT_FIFO_DEPTH));
    assign empty_c    = (wr_ptr_q == rd_ptr_q);
    assign ready_c    = !full_c && (state_q != HALT);
    assign push_c     = bus.cmp_pkt_en_i && ready_c && !bus.start_test_i;
    assign total_c    = (head_c.burstcount == '0) ? {1'b1, {AMM_BURST_W{1'b0}}}
                                                  : {1'b0, head_c.burstcount};

    // A word arriving in LOAD is the new packet's first word, so its context comes from the FIFO head.
    always_comb begin
        cur_addr  = addr_q;
        cur_start = start_q;
        cur_end   = end_q;
        cur_ptrn  = ptrn_q;
        cur_rnd   = rnd_q;
        cur_lfsr  = lfsr_q;
        cur_idx   = idx_q;
        cur_left  = left_q;
        if (state_q == LOAD) begin
            cur_addr  = head_c.word_addr;
            cur_start = head_c.start_off;
            cur_end   = head_c.end_off;
            cur_ptrn  = head_c.ptrn;
            cur_rnd   = head_c.rnd;
            cur_lfsr  = head_c.ptrn;
            cur_idx   = '0;
            cur_left  = total_c;
        end
        exp_c      = cur_rnd ? cur_lfsr : cur_ptrn;
        lfsr_nxt_c = {cur_lfsr[6:0], cur_lfsr[6] ^ cur_lfsr[1] ^ cur_lfsr[0]};
        first_c    = (cur_idx == '0);
        last_c     = (cur_left == CNT_W'(1));
        word_acc_c = bus.readdatavalid_i && !bus.start_test_i
                     && ((state_q == LOAD) || (state_q == CHECK));
        fail_c     = '0;
        for (int unsigned i = 0; i < BYTE_PER_WORD; i++) begin
            if ((!first_c || (BYTE_ADDR_W'(i) >= cur_start))
                && (!last_c || (BYTE_ADDR_W'(i) <= cur_end))
                && (bus.readdata_i[8*i +: 8] != exp_c)) begin
                fail_c[i] = 1'b1;
            end
        end
        halt_c = word_acc_c && (|fail_c) && !bus.cont_on_err_i;
    end

    // Packet FIFO storage.
    always_ff @(posedge clk_i) begin
        if (push_c) begin
            fifo_q[wr_ptr_q[PTR_W-1:0]] <= pkt_in_c;
        end
    end

    // Control FSM, FIFO pointers and active packet context.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            addr_q   <= '0;
            start_q  <= '0;
            end_q    <= '0;
            ptrn_q   <= '0;
            rnd_q    <= 1'b0;
            lfsr_q   <= '0;
            idx_q    <= '0;
            left_q   <= '0;
        end else if (bus.start_test_i) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + PCNT_W'(1);
            end
            case (state_q)
                IDLE: begin
                    if (!empty_c) begin
                        state_q <= LOAD;
                    end
                end
                LOAD, CHECK: begin
                    if (state_q == LOAD) begin
                        rd_ptr_q <= rd_ptr_q + PCNT_W'(1);
                    end
                    addr_q  <= cur_addr;
                    start_q <= cur_start;
                    end_q   <= cur_end;
                    ptrn_q  <= cur_ptrn;
                    rnd_q   <= cur_rnd;
                    idx_q   <= word_acc_c ? cur_idx + CNT_W'(1) : cur_idx;
                    left_q  <= word_acc_c ? cur_left - CNT_W'(1) : cur_left;
                    lfsr_q  <= word_acc_c ? lfsr_nxt_c : cur_lfsr;
                    if (halt_c) begin
                        state_q <= HALT;
                    end else if (word_acc_c && last_c) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= CHECK;
                    end
                end
                HALT: begin
                    rd_ptr_q <= wr_ptr_q;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Compare stage: capture failing lanes and word address of each accepted word.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_vld_q  <= 1'b0;
            s1_last_q <= 1'b0;
            s1_fail_q <= '0;
            s1_addr_q <= '0;
        end else begin
            s1_vld_q <= word_acc_c;
            if (word_acc_c) begin
                s1_last_q <= last_c;
                s1_fail_q <= fail_c;
                s1_addr_q <= cur_addr + ADDR_W'(cur_idx);
            end
        end
    end

    // Lowest failing byte lane of the captured word.
    always_comb begin
        s1_err_c  = |s1_fail_q;
        low_idx_c = '0;
        for (int i = int'(BYTE_PER_WORD) - 1; i >= 0; i--) begin
            if (s1_fail_q[i]) begin
                low_idx_c = BYTE_ADDR_W'(i);
            end
        end
    end

    // Result stage: error/pass pulses, error address, saturating counter, unexpected-data flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q    <= 1'b0;
            result_q   <= 1'b0;
            err_addr_q <= '0;
            err_cnt_q  <= '0;
            unexp_q    <= 1'b0;
            pkt_err_q  <= 1'b0;
        end else if (bus.start_test_i) begin
            valid_q    <= 1'b0;
            err_cnt_q  <= '0;
            unexp_q    <= 1'b0;
            pkt_err_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (bus.readdatavalid_i && (state_q == IDLE)) begin
                unexp_q <= 1'b1;
            end
            if (s1_vld_q) begin
                pkt_err_q <= s1_last_q ? 1'b0 : (pkt_err_q | s1_err_c);
                if (s1_err_c) begin
                    valid_q    <= 1'b1;
                    result_q   <= 1'b0;
                    err_addr_q <= {s1_addr_q, low_idx_c};
                    if (err_cnt_q != '1) begin
                        err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
                    end
                end else if (s1_last_q && !pkt_err_q) begin
                    valid_q    <= 1'b1;
                    result_q   <= 1'b1;
                    err_addr_q <= {s1_addr_q, BYTE_ADDR_W'(0)};
                end
            end
        end
    end

    assign bus.cmp_pkt_ready_o       = ready_c;
    assign bus.check_result_valid_o  = valid_q;
    assign bus.check_result_o        = result_q;
    assign bus.check_error_address_o = err_addr_q;
    assign bus.error_cnt_o           = err_cnt_q;
    assign bus.unexp_data_o          = unexp_q;
    assign bus.busy_o                = (state_q != IDLE) || !empty_c || s1_vld_q;

endmodule

// File: tb/tb_burst_compare_engine.sv
// Directed bench for burst_compare_engine with default parameters.
module tb_burst_compare_engine;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [127:0] d;

    burst_compare_engine_if #(
        .AMM_DATA_W(128), .AMM_ADDR_W(12), .AMM_BURST_W(11), .ERR_CNT_W(16)
    ) bus_if ();

    burst_compare_engine #(
        .AMM_DATA_W(128), .AMM_ADDR_W(12), .AMM_BURST_W(11),
        .PKT_FIFO_DEPTH(4), .ERR_CNT_W(16)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus_if)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rep(input logic [7:0] b);
        return {16{b}};
    endfunction

    task automatic push(input logic [7:0] addr, input logic [10:0] burst,
                        input logic [3:0] so, input logic [3:0] eo,
                        input logic [7:0] ptrn, input logic rnd);
        bus_if.cmp_word_addr_i  = addr;
        bus_if.cmp_burstcount_i = burst;
        bus_if.cmp_start_off_i  = so;
        bus_if.cmp_end_off_i    = eo;
        bus_if.cmp_data_ptrn_i  = ptrn;
        bus_if.cmp_data_rnd_i   = rnd;
        bus_if.cmp_pkt_en_i     = 1'b1;
        step();
        bus_if.cmp_pkt_en_i     = 1'b0;
    endtask

    task automatic send(input logic [127:0] data);
        bus_if.readdata_i      = data;
        bus_if.readdatavalid_i = 1'b1;
        step();
        bus_if.readdatavalid_i = 1'b0;
        bus_if.readdata_i      = '0;
    endtask

    initial begin
        bus_if.start_test_i     = 1'b0;
        bus_if.cont_on_err_i    = 1'b0;
        bus_if.readdatavalid_i  = 1'b0;
        bus_if.readdata_i       = '0;
        bus_if.cmp_pkt_en_i     = 1'b0;
        bus_if.cmp_word_addr_i  = '0;
        bus_if.cmp_burstcount_i = '0;
        bus_if.cmp_start_off_i  = '0;
        bus_if.cmp_end_off_i    = '0;
        bus_if.cmp_data_ptrn_i  = '0;
        bus_if.cmp_data_rnd_i   = 1'b0;
        repeat (3) step();

        // Reset state
        chk("rst_valid", 32'(bus_if.check_result_valid_o), 0);
        chk("rst_result", 32'(bus_if.check_result_o), 0);
        chk("rst_addr", 32'(bus_if.check_error_address_o), 0);
        chk("rst_cnt", 32'(bus_if.error_cnt_o), 0);
        chk("rst_unexp", 32'(bus_if.unexp_data_o), 0);
        chk("rst_busy", 32'(bus_if.busy_o), 0);
        chk("rst_ready", 32'(bus_if.cmp_pkt_ready_o), 1);
        rst_i = 1'b0;
        step();

        // Fixed pattern pass, burst 4, offsets 3/5, garbage outside the mask
        push(8'h10, 11'd4, 4'd3, 4'd5, 8'hA5, 1'b0);
        repeat (3) step();
        send({{13{8'hA5}}, {3{8'h00}}});
        send(rep(8'hA5));
        send(rep(8'hA5));
        chk("p1_no_early_pulse", 32'(bus_if.check_result_valid_o), 0);
        send({{10{8'h00}}, {6{8'hA5}}});
        chk("p1_pulse_lat1", 32'(bus_if.check_result_valid_o), 0);
        step();
        chk("p1_valid", 32'(bus_if.check_result_valid_o), 1);
        chk("p1_result", 32'(bus_if.check_result_o), 1);
        chk("p1_addr", 32'(bus_if.check_error_address_o), 32'h130);
        step();
        chk("p1_single_pulse", 32'(bus_if.check_result_valid_o), 0);

        // Halt on first error: word 2 byte 7 corrupt
        push(8'h10, 11'd4, 4'd3, 4'd5, 8'hA5, 1'b0);
        repeat (3) step();
        send(rep(8'hA5));
        send(rep(8'hA5));
        d = rep(8'hA5);
        d[7*8 +: 8] = 8'h00;
        send(d);
        send(rep(8'h00));
        chk("halt_valid", 32'(bus_if.check_result_valid_o), 1);
        chk("halt_result", 32'(bus_if.check_result_o), 0);
        chk("halt_addr", 32'(bus_if.check_error_address_o), 32'h127);
        chk("halt_cnt", 32'(bus_if.error_cnt_o), 1);
        push(8'h50, 11'd1, 4'd0, 4'd15, 8'h00, 1'b0);
        repeat (3) step();
        chk("halt_ready", 32'(bus_if.cmp_pkt_ready_o), 0);
        chk("halt_cnt_hold", 32'(bus_if.error_cnt_o), 1);
        chk("halt_busy", 32'(bus_if.busy_o), 1);
        bus_if.start_test_i = 1'b1;
        step();
        bus_if.start_test_i = 1'b0;
        chk("restart_ready", 32'(bus_if.cmp_pkt_ready_o), 1);
        chk("restart_cnt", 32'(bus_if.error_cnt_o), 0);
        chk("restart_busy", 32'(bus_if.busy_o), 0);

        // Continue on error: words 0 and 2 corrupt
        bus_if.cont_on_err_i = 1'b1;
        push(8'h20, 11'd3, 4'd0, 4'd15, 8'h5A, 1'b0);
        repeat (3) step();
        d = rep(8'h5A);
        d[5*8 +: 8] = 8'h00;
        send(d);
        chk("cont_w0_lat", 32'(bus_if.check_result_valid_o), 0);
        send(rep(8'h5A));
        chk("cont_e1_valid", 32'(bus_if.check_result_valid_o), 1);
        chk("cont_e1_result", 32'(bus_if.check_result_o), 0);
        chk("cont_e1_addr", 32'(bus_if.check_error_address_o), 32'h205);
        chk("cont_e1_cnt", 32'(bus_if.error_cnt_o), 1);
        d = rep(8'h5A);
        d[0 +: 8] = 8'hFF;
        d[9*8 +: 8] = 8'hFF;
        send(d);
        chk("cont_w1_ok", 32'(bus_if.check_result_valid_o), 0);
        step();
        chk("cont_e2_valid", 32'(bus_if.check_result_valid_o), 1);
        chk("cont_e2_result", 32'(bus_if.check_result_o), 0);
        chk("cont_e2_addr", 32'(bus_if.check_error_address_o), 32'h220);
        chk("cont_e2_cnt", 32'(bus_if.error_cnt_o), 2);
        step();
        chk("cont_no_pass", 32'(bus_if.check_result_valid_o), 0);
        bus_if.cont_on_err_i = 1'b0;

        // LFSR seed 0x01, single-byte first word, address wrap 0xFF+2
        push(8'hFF, 11'd3, 4'd15, 4'd15, 8'h01, 1'b1);
        repeat (3) step();
        send({8'h01, {15{8'hEE}}});
        send(rep(8'h03));
        send(rep(8'h06));
        step();
        chk("lfsr_valid", 32'(bus_if.check_result_valid_o), 1);
        chk("lfsr_result", 32'(bus_if.check_result_o), 1);
        chk("lfsr_addr", 32'(bus_if.check_error_address_o), 32'h010);
        chk("lfsr_cnt", 32'(bus_if.error_cnt_o), 2);

        // Burstcount 0 means 2048 words
        push(8'h00, 11'd0, 4'd0, 4'd15, 8'h3C, 1'b0);
        repeat (3) step();
        for (int i = 0; i < 2048; i++) begin
            send(rep(8'h3C));
        end
        chk("b0_lat", 32'(bus_if.check_result_valid_o), 0);
        step();
        chk("b0_valid", 32'(bus_if.check_result_valid_o), 1);
        chk("b0_result", 32'(bus_if.check_result_o), 1);
        chk("b0_addr", 32'(bus_if.check_error_address_o), 32'hFF0);

        // start_test wins over a simultaneous packet write
        bus_if.start_test_i = 1'b1;
        push(8'h60, 11'd1, 4'd0, 4'd15, 8'h00, 1'b0);
        bus_if.start_test_i = 1'b0;
        chk("start_drop_busy", 32'(bus_if.busy_o), 0);
        chk("start_cnt_clr", 32'(bus_if.error_cnt_o), 0);

        // FIFO fill: five writes, one popped into LOAD, sixth dropped
        bus_if.cmp_burstcount_i = 11'd1;
        bus_if.cmp_start_off_i  = 4'd0;
        bus_if.cmp_end_off_i    = 4'd15;
        bus_if.cmp_data_ptrn_i  = 8'h77;
        bus_if.cmp_data_rnd_i   = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus_if.cmp_word_addr_i = 8'h40 + 8'(k);
            bus_if.cmp_pkt_en_i    = 1'b1;
            step();
            if (k == 3) chk("fill_ready_4th", 32'(bus_if.cmp_pkt_ready_o), 1);
            if (k >= 4) chk("fill_ready_full", 32'(bus_if.cmp_pkt_ready_o), 0);
        end
        bus_if.cmp_pkt_en_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            send(rep(8'h77));
            chk("fifo_lat", 32'(bus_if.check_result_valid_o), 0);
            step();
            chk("fifo_valid", 32'(bus_if.check_result_valid_o), 1);
            chk("fifo_addr", 32'(bus_if.check_error_address_o), 32'h400 + 32'(k) * 32'h10);
            step();
            if (k == 0) chk("fifo_ready_after_pop", 32'(bus_if.cmp_pkt_ready_o), 1);
        end
        chk("fifo_drained_busy", 32'(bus_if.busy_o), 0);
        chk("unexp_before", 32'(bus_if.unexp_data_o), 0);
        send(rep(8'h77));
        chk("unexp_set", 32'(bus_if.unexp_data_o), 1);
        repeat (3) step();
        chk("unexp_sticky", 32'(bus_if.unexp_data_o), 1);
        chk("unexp_no_pulse", 32'(bus_if.check_result_valid_o), 0);

        // Reset mid-burst
        push(8'h30, 11'd4, 4'd0, 4'd15, 8'hC3, 1'b0);
        repeat (3) step();
        send(rep(8'hC3));
        bus_if.readdata_i      = rep(8'hC3);
        bus_if.readdatavalid_i = 1'b1;
        #2;
        rst_i = 1'b1;
        #1;
        bus_if.readdatavalid_i = 1'b0;
        chk("mid_rst_valid", 32'(bus_if.check_result_valid_o), 0);
        chk("mid_rst_result", 32'(bus_if.check_result_o), 0);
        chk("mid_rst_addr", 32'(bus_if.check_error_address_o), 0);
        chk("mid_rst_unexp", 32'(bus_if.unexp_data_o), 0);
        chk("mid_rst_busy", 32'(bus_if.busy_o), 0);
        chk("mid_rst_ready", 32'(bus_if.cmp_pkt_ready_o), 1);
        step();
        rst_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("post_rst_no_pulse", 32'(bus_if.check_result_valid_o), 0);
        end
        chk("post_rst_busy", 32'(bus_if.busy_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
